// File: rtl/dbg_ocimem_pkg.sv
// Shared types and jdo field positions for the on-chip debug memory controller.
package dbg_ocimem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_JRD,
    ST_JCAP,
    ST_JWR,
    ST_CRD,
    ST_CDATA
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_ADDR,
    OP_RD,
    OP_SRD,
    OP_WR
  } op_e;

  localparam int JDO_RD_BIT    = 35;
  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_WDATA_MSB = 34;
  localparam int JDO_WDATA_LSB = 3;

  function automatic logic is_jtag_state(state_e s);
    return (s == ST_JRD) || (s == ST_JCAP) || (s == ST_JWR);
  endfunction

endpackage

// File: rtl/dbg_ocimem_ram.sv
// Single-port 32-bit debug RAM with byte enables and a registered read port.
module dbg_ocimem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;

  // Read-during-write returns the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dbg_ocimem_ctrl.sv
// Debug memory controller: JTAG monitor access (priority) and CPU Avalon-MM access to one RAM.
// Define DBG_OCIMEM_CPU_WRPROT_EN to block non-debug CPU writes and flag them in cpu_wr_viol.
//
// state    | meaning
// IDLE     | serve pending JTAG op, else CPU read/write, else a fresh strobe
// JRD      | RAM addressed with MonAReg for a JTAG read
// JCAP     | RAM data captured into MonDReg, monitor_ready set
// JWR      | JTAG word written at MonAReg, address advances
// CRD      | RAM addressed for CPU read, bus stalled
// CDATA    | CPU read data valid, stall released
module dbg_ocimem_ctrl
  import dbg_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  input  logic              avs_debugaccess,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic              cpu_wr_viol
);

  state_e            state_q, state_d;
  op_e               pend_op_q, pend_op_d;
  logic [31:0]       pend_data_q, pend_data_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic              rd_mode_q, rd_mode_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;

  op_e               new_op, serve_op;
  logic              can_accept, cpu_rd, cpu_wr_done, wr_ok;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata, ram_rdata;
  logic              unused_jdo;

  assign cpu_rd     = avs_read & ~avs_write;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  always_comb begin
    state_d     = state_q;
    pend_op_d   = pend_op_q;
    pend_data_d = pend_data_q;
    mon_a_d     = mon_a_q;
    mon_d_d     = mon_d_q;
    rd_mode_d   = rd_mode_q;
    ready_d     = ready_q;
    error_d     = error_q;
    serve_op    = OP_NONE;
    cpu_wr_done = 1'b0;
    ram_addr    = avs_address;
    ram_we      = 1'b0;
    ram_be      = avs_byteenable;
    ram_wdata   = avs_writedata;

    if (take_action_ocimem_a)                    new_op = jdo[JDO_RD_BIT] ? OP_RD : OP_ADDR;
    else if (take_action_ocimem_b)               new_op = OP_WR;
    else if (take_no_action_ocimem_a && rd_mode_q) new_op = OP_SRD;
    else                                         new_op = OP_NONE;

    can_accept = (pend_op_q == OP_NONE) && !is_jtag_state(state_q);

    if (new_op != OP_NONE) begin
      if (can_accept) begin
        pend_op_d   = new_op;
        pend_data_d = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
        ready_d     = 1'b0;
        if (take_action_ocimem_a) begin
          mon_a_d   = jdo[JDO_ADDR_LSB +: ADDR_W];
          rd_mode_d = jdo[JDO_RD_BIT];
          error_d   = 1'b0;
        end
      end else begin
        error_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        // A strobe arriving alongside a CPU request waits one turn in pending.
        if (pend_op_q != OP_NONE) serve_op = pend_op_q;
        else if (cpu_rd)          state_d  = ST_CRD;
        else if (avs_write) begin
          cpu_wr_done = 1'b1;
          ram_we      = wr_ok;
        end
        else                      serve_op = new_op;

        case (serve_op)
          OP_ADDR: begin
            pend_op_d = OP_NONE;
            ready_d   = 1'b1;
          end
          OP_RD:   state_d = ST_JRD;
          OP_SRD: begin
            mon_a_d = mon_a_q + 1'b1;
            state_d = ST_JRD;
          end
          OP_WR:   state_d = ST_JWR;
          default: ;
        endcase
      end
      ST_JRD: begin
        ram_addr = mon_a_q;
        state_d  = ST_JCAP;
      end
      ST_JCAP: begin
        mon_d_d   = ram_rdata;
        ready_d   = 1'b1;
        pend_op_d = OP_NONE;
        state_d   = ST_IDLE;
      end
      ST_JWR: begin
        ram_addr  = mon_a_q;
        ram_we    = 1'b1;
        ram_be    = 4'hF;
        ram_wdata = pend_data_q;
        mon_d_d   = pend_data_q;
        mon_a_d   = mon_a_q + 1'b1;
        ready_d   = 1'b1;
        pend_op_d = OP_NONE;
        state_d   = ST_IDLE;
      end
      ST_CRD:   state_d = ST_CDATA;
      ST_CDATA: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      pend_op_q   <= OP_NONE;
      pend_data_q <= '0;
      mon_a_q     <= '0;
      mon_d_q     <= '0;
      rd_mode_q   <= 1'b0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_op_q   <= pend_op_d;
      pend_data_q <= pend_data_d;
      mon_a_q     <= mon_a_d;
      mon_d_q     <= mon_d_d;
      rd_mode_q   <= rd_mode_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
    end
  end

`ifdef DBG_OCIMEM_CPU_WRPROT_EN
  logic viol_q;
  assign wr_ok = avs_debugaccess;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          viol_q <= 1'b0;
    else if (cpu_wr_done && !avs_debugaccess) viol_q <= 1'b1;
  end
  assign cpu_wr_viol = viol_q;
`else
  logic unused_prot;
  assign wr_ok       = 1'b1;
  assign cpu_wr_viol = 1'b0;
  assign unused_prot = avs_debugaccess ^ cpu_wr_done;
`endif

  dbg_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk_i   (clk),
    .addr_i  (ram_addr),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign avs_waitrequest = (avs_read | avs_write) &
                           ~((state_q == ST_CDATA) ||
                             ((state_q == ST_IDLE) && avs_write && (pend_op_q == OP_NONE)));
  assign avs_readdata    = (state_q == ST_CDATA) ? ram_rdata : '0;
  assign MonDReg         = mon_d_q;
  assign monitor_ready   = ready_q;
  assign monitor_error   = error_q;

endmodule

// File: tb/tb_dbg_ocimem_ctrl.sv
// Randomized bench for dbg_ocimem_ctrl against a word-array model of the debug RAM and monitor registers.
module tb_dbg_ocimem_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;
  logic [7:0]  avs_address = '0;
  logic        avs_read = 1'b0, avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [3:0]  avs_byteenable = '0;
  logic        avs_debugaccess = 1'b1;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest, cpu_wr_viol;

  dbg_ocimem_ctrl #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_debugaccess         (avs_debugaccess),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .cpu_wr_viol             (cpu_wr_viol)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model
  logic [31:0] mem [256];
  logic [7:0]  m_a = '0;
  logic        m_rd = 1'b0;
  logic [31:0] m_d = '0;
  logic        m_viol = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be, input logic dbg);
    bit done;
    done = 0;
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_debugaccess = dbg; avs_write = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!avs_waitrequest) done = 1;
      tick();
      if (done) break;
    end
    avs_write = 1'b0;
    avs_debugaccess = 1'b1;
    if (!done) check("cpu_write_timeout", 32'd0, 32'd1);
`ifdef DBG_OCIMEM_CPU_WRPROT_EN
    if (!dbg) begin
      m_viol = 1'b1;
      return;
    end
`endif
    for (int b = 0; b < 4; b++) if (be[b]) mem[a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic cpu_read(input logic [7:0] a, output logic [31:0] d, output int lat);
    avs_address = a; avs_read = 1'b1; d = '0; lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!avs_waitrequest) begin
        d = avs_readdata;
        lat = c;
        tick();
        break;
      end
      tick();
    end
    avs_read = 1'b0;
  endtask

  task automatic cpu_read_chk(input string tag, input logic [7:0] a);
    logic [31:0] d;
    int lat;
    cpu_read(a, d, lat);
    check(tag, d, mem[a]);
  endtask

  task automatic pulse_a(input logic [7:0] a, input logic rd);
    jdo = '0; jdo[35] = rd; jdo[24:17] = a;
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
  endtask

  task automatic pulse_b(input logic [31:0] d);
    jdo = '0; jdo[34:3] = d;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic pulse_n();
    jdo = {6'h3F, 32'h5A5A_5A5A};
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    bit ok;
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (monitor_ready) begin
        ok = 1;
        break;
      end
    end
    tick();
    if (!ok) check(tag, 32'd0, 32'd1);
  endtask

  task automatic jtag_read(input logic [7:0] a);
    pulse_a(a, 1'b1);
    m_a = a; m_rd = 1'b1; m_d = mem[a];
    wait_ready("jrd_timeout");
    check("jrd_data", MonDReg, m_d);
  endtask

  task automatic jtag_addr(input logic [7:0] a);
    pulse_a(a, 1'b0);
    m_a = a; m_rd = 1'b0;
    wait_ready("jaddr_timeout");
  endtask

  task automatic jtag_write(input logic [31:0] d);
    pulse_b(d);
    mem[m_a] = d; m_d = d; m_a = m_a + 8'd1;
    wait_ready("jwr_timeout");
    check("jwr_mondreg", MonDReg, m_d);
  endtask

  task automatic jtag_stream();
    pulse_n();
    if (m_rd) begin
      m_a = m_a + 8'd1; m_d = mem[m_a];
      wait_ready("jstream_timeout");
      check("jstream_data", MonDReg, m_d);
    end else begin
      @(negedge clk);
      check("jstream_ignored_ready", monitor_ready, 1'b1);
      check("jstream_ignored_err", monitor_error, 1'b0);
      tick();
    end
  endtask

  initial begin
    logic [31:0] d;
    int lat;

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_mondreg", MonDReg, 32'd0);
    check("rst_ready", monitor_ready, 1'b0);
    check("rst_error", monitor_error, 1'b0);
    check("rst_readdata", avs_readdata, 32'd0);
    check("rst_viol", cpu_wr_viol, 1'b0);
    check("rst_waitreq", avs_waitrequest, 1'b0);
    tick();

    for (int i = 0; i < 256; i++) cpu_write(i[7:0], $urandom, 4'hF, 1'b1);

    // JTAG read with exact latency
    cpu_write(8'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    pulse_a(8'h10, 1'b1);
    m_a = 8'h10; m_rd = 1'b1; m_d = mem[8'h10];
    @(negedge clk); check("jrd_c1_ready", monitor_ready, 1'b0); tick();
    @(negedge clk); check("jrd_c2_ready", monitor_ready, 1'b0); tick();
    @(negedge clk); check("jrd_c3_ready", monitor_ready, 1'b1);
    check("jrd_c3_data", MonDReg, 32'hDEADBEEF); tick();

    // streamed write with wrap
    jtag_addr(8'hFF);
    jtag_write(32'h11111111);
    jtag_write(32'h22222222);
    cpu_read(8'hFF, d, lat); check("wrap_ff", d, 32'h11111111); check("cpu_rd_lat", lat, 2);
    cpu_read(8'h00, d, lat); check("wrap_00", d, 32'h22222222);
    check("wrap_err", monitor_error, 1'b0);

    // streamed reads and ignored stream with rd_mode=0
    jtag_read(8'h30);
    jtag_stream();
    jtag_stream();
    jtag_addr(8'h50);
    jtag_stream();

    // JTAG write strobe during a CPU read
    cpu_write(8'h05, 32'hA5A5A5A5, 4'hF, 1'b1);
    jtag_addr(8'h60);
    avs_address = 8'h05; avs_read = 1'b1;
    @(negedge clk); check("col_c0_wait", avs_waitrequest, 1'b1); tick();
    jdo = '0; jdo[34:3] = 32'h77777777; take_action_ocimem_b = 1'b1;
    @(negedge clk); check("col_c1_wait", avs_waitrequest, 1'b1); tick();
    take_action_ocimem_b = 1'b0;
    @(negedge clk); check("col_c2_wait", avs_waitrequest, 1'b0);
    check("col_c2_data", avs_readdata, 32'hA5A5A5A5); tick();
    avs_read = 1'b0;
    mem[8'h60] = 32'h77777777; m_d = 32'h77777777; m_a = 8'h61;
    @(negedge clk); check("col_c3_ready", monitor_ready, 1'b0); tick();
    @(negedge clk); check("col_c4_ready", monitor_ready, 1'b0); tick();
    @(negedge clk); check("col_c5_ready", monitor_ready, 1'b1); tick();
    check("col_mondreg", MonDReg, 32'h77777777);
    check("col_err", monitor_error, 1'b0);
    cpu_read_chk("col_ram60", 8'h60);

    // overrun: second a strobe while the first read is in flight
    pulse_a(8'h10, 1'b1);
    pulse_a(8'h41, 1'b0);
    m_a = 8'h10; m_rd = 1'b1; m_d = mem[8'h10];
    wait_ready("ovr_timeout");
    check("ovr_mondreg", MonDReg, m_d);
    check("ovr_err_set", monitor_error, 1'b1);
    jtag_write(32'hCAFEF00D);
    check("ovr_err_sticky", monitor_error, 1'b1);
    cpu_read_chk("ovr_ram11", 8'h11);
    cpu_read_chk("ovr_ram42", 8'h42);
    jtag_addr(8'h70);
    check("ovr_err_clr", monitor_error, 1'b0);

    // randomized mix
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 4))
        0: cpu_write($urandom, $urandom, 4'($urandom), 1'b1);
        1: cpu_read_chk("rnd_cpu_rd", 8'($urandom));
        2: jtag_read(8'($urandom));
        3: begin
          jtag_addr(8'($urandom));
          repeat ($urandom_range(1, 3)) jtag_write($urandom);
        end
        default: jtag_stream();
      endcase
      check("rnd_err", monitor_error, 1'b0);
      check("rnd_viol", cpu_wr_viol, m_viol);
    end

    // reset in the middle of a JTAG read
    pulse_a(8'h10, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_mondreg", MonDReg, 32'd0);
    check("mid_rst_ready", monitor_ready, 1'b0);
    check("mid_rst_error", monitor_error, 1'b0);
    check("mid_rst_readdata", avs_readdata, 32'd0);
    check("mid_rst_viol", cpu_wr_viol, 1'b0);
    m_a = '0; m_rd = 1'b0; m_d = '0; m_viol = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_wait", avs_waitrequest, 1'b0);
      check("post_rst_ready", monitor_ready, 1'b0);
      tick();
    end
    cpu_read(8'h10, d, lat);
    check("post_rst_rd", d, mem[8'h10]);
    check("post_rst_lat", lat, 2);
    jtag_read(8'h10);

    // CPU write without debug access
    cpu_write(8'h20, 32'h12345678, 4'hF, 1'b0);
    cpu_read_chk("prot_ram20", 8'h20);
`ifdef DBG_OCIMEM_CPU_WRPROT_EN
    check("prot_viol", cpu_wr_viol, 1'b1);
`else
    check("prot_ram20_val", mem[8'h20], 32'h12345678);
    check("prot_viol", cpu_wr_viol, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
